// File: rtl/ham_15_11_pkg.sv
// ham_15_11_pkg
// Shared definitions for the Hamming(15,11) encoder/decoder pair:
//   - code geometry constants (HAM_N, HAM_K) and parity-bit positions
//   - serial encoder FSM state type and last-bit index
//   - ham_encode(): data word -> codeword, also the reference model for
//     the decoder bench
package ham_15_11_pkg;

  localparam int unsigned HAM_N = 32'd15;
  localparam int unsigned HAM_K = 32'd11;

  // Parity bits sit at the power-of-two positions (1-based 1, 2, 4, 8)
  localparam int unsigned PAR_POS_0 = 32'd0;
  localparam int unsigned PAR_POS_1 = 32'd1;
  localparam int unsigned PAR_POS_2 = 32'd3;
  localparam int unsigned PAR_POS_3 = 32'd7;

  // Index of the final serial bit (c[14])
  localparam logic [3:0] LAST_IDX = 4'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } enc_state_t;

  // Place data bits in the non-parity positions, then fill parity so that
  // the syndrome of a clean word is zero.
  function automatic logic [14:0] ham_encode(input logic [10:0] d);
    logic [14:0] c;
    c      = 15'd0;
    c[2]   = d[0];
    c[4]   = d[1];
    c[5]   = d[2];
    c[6]   = d[3];
    c[8]   = d[4];
    c[9]   = d[5];
    c[10]  = d[6];
    c[11]  = d[7];
    c[12]  = d[8];
    c[13]  = d[9];
    c[14]  = d[10];
    c[PAR_POS_0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
    c[PAR_POS_1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[PAR_POS_2] = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[PAR_POS_3] = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    return c;
  endfunction

endpackage

// File: rtl/ham_15_11_serial_encoder_if.sv
// ham_15_11_serial_encoder_if
// Bundles the encoder's word-input handshake and its parallel/serial
// codeword outputs.
//   master : upstream/bench side (drives in_data, in_valid, inj_pos)
//   slave  : encoder side (drives in_ready, cw*, ser_*, sof, eof, words_sent)
interface ham_15_11_serial_encoder_if;

  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  inj_pos;
  logic [14:0] cw;
  logic        cw_valid;
  logic        ser_out;
  logic        ser_valid;
  logic        sof;
  logic        eof;
  logic [15:0] words_sent;

  modport master (
    output in_data, in_valid, inj_pos,
    input  in_ready, cw, cw_valid, ser_out, ser_valid, sof, eof, words_sent
  );

  modport slave (
    input  in_data, in_valid, inj_pos,
    output in_ready, cw, cw_valid, ser_out, ser_valid, sof, eof, words_sent
  );

endinterface

// File: rtl/ham_15_11_encode_comb.sv
// ham_15_11_encode_comb
// Purely combinational Hamming(15,11) encoder with single-bit error
// injection applied after parity generation.
//   data    in  11 : data word d[10:0]
//   inj_pos in  4  : 0 = clean, k = invert c[k-1]
//   cw      out 15 : encoded, possibly corrupted, codeword
module ham_15_11_encode_comb
  import ham_15_11_pkg::*;
(
  input  logic [HAM_K-32'd1:0] data,
  input  logic [3:0]           inj_pos,
  output logic [HAM_N-32'd1:0] cw
);

  logic [14:0] base_s;
  logic [14:0] mask_s;

  // Encode, then flip the requested bit; numbering matches the decoder's
  // syndrome (syndrome k flags c[k-1]).
  always_comb begin
    base_s = ham_encode(data);
    mask_s = 15'd0;
    if (inj_pos != 4'd0) begin
      mask_s = 15'd1 << (inj_pos - 4'd1);
    end else begin
      mask_s = 15'd0;
    end
    cw = base_s ^ mask_s;
  end

endmodule

// File: rtl/ham_15_11_serial_encoder.sv
// ham_15_11_serial_encoder
// Accepts 11-bit words over valid/ready, presents the Hamming(15,11)
// codeword in parallel for one cycle and shifts it out LSB first over 15
// cycles. Frames stream back-to-back when a new word is offered at the last
// bit.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of ham_15_11_serial_encoder_if
//         (in_data/in_valid/inj_pos in; in_ready, cw, cw_valid, ser_out,
//          ser_valid, sof, eof, words_sent out)
module ham_15_11_serial_encoder
  import ham_15_11_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  ham_15_11_serial_encoder_if.slave   bus
);

  enc_state_t  state_r;
  enc_state_t  state_n_s;
  logic [3:0]  idx_r;
  logic [3:0]  idx_n_s;
  logic [14:0] shreg_r;
  logic [14:0] shreg_n_s;
  logic [14:0] enc_cw_s;
  logic [14:0] cw_r;
  logic        cw_valid_r;
  logic        ser_valid_r;
  logic        sof_r;
  logic        eof_r;
  logic [15:0] words_sent_r;
  logic        in_ready_s;
  logic        accept_s;

  ham_15_11_encode_comb u_encode (
    .data    (bus.in_data),
    .inj_pos (bus.inj_pos),
    .cw      (enc_cw_s)
  );

  // Ready while idle or on the last bit; held low during reset so nothing
  // is accepted in a cycle that is being reset.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      in_ready_s = 1'b1;
    end else if (idx_r == LAST_IDX) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = bus.in_valid & in_ready_s;
  end

  // Next-state logic: load on accept, otherwise shift or drop back to idle.
  always_comb begin
    state_n_s = state_r;
    idx_n_s   = idx_r;
    shreg_n_s = shreg_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n_s = ST_SHIFT;
          idx_n_s   = 4'd0;
          shreg_n_s = enc_cw_s;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (accept_s) begin
          state_n_s = ST_SHIFT;
          idx_n_s   = 4'd0;
          shreg_n_s = enc_cw_s;
        end else if (idx_r == LAST_IDX) begin
          // Clear so ser_out idles at 0 between frames
          state_n_s = ST_IDLE;
          idx_n_s   = 4'd0;
          shreg_n_s = 15'd0;
        end else begin
          state_n_s = ST_SHIFT;
          idx_n_s   = idx_r + 4'd1;
          shreg_n_s = {1'b0, shreg_r[14:1]};
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        idx_n_s   = 4'd0;
        shreg_n_s = 15'd0;
      end
    endcase
  end

  // State, shift register and registered frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= 4'd0;
      shreg_r      <= 15'd0;
      cw_r         <= 15'd0;
      cw_valid_r   <= 1'b0;
      ser_valid_r  <= 1'b0;
      sof_r        <= 1'b0;
      eof_r        <= 1'b0;
      words_sent_r <= 16'd0;
    end else begin
      state_r     <= state_n_s;
      idx_r       <= idx_n_s;
      shreg_r     <= shreg_n_s;
      cw_valid_r  <= accept_s;
      sof_r       <= accept_s;
      ser_valid_r <= (state_n_s == ST_SHIFT);
      eof_r       <= (state_n_s == ST_SHIFT) && (idx_n_s == LAST_IDX);
      if (accept_s) begin
        cw_r <= enc_cw_s;
      end else begin
        cw_r <= cw_r;
      end
      // Count the frame during the cycle its last bit is on the wire
      if (eof_r) begin
        words_sent_r <= words_sent_r + 16'd1;
      end else begin
        words_sent_r <= words_sent_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.cw         = cw_r;
  assign bus.cw_valid   = cw_valid_r;
  assign bus.ser_out    = shreg_r[0];
  assign bus.ser_valid  = ser_valid_r;
  assign bus.sof        = sof_r;
  assign bus.eof        = eof_r;
  assign bus.words_sent = words_sent_r;

endmodule

// File: tb/tb_ham_15_11_serial_encoder.sv
// Directed self-checking bench for ham_15_11_serial_encoder.
module tb_ham_15_11_serial_encoder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [15:0] exp_ws;

  ham_15_11_serial_encoder_if bus ();

  ham_15_11_serial_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one word, then check the parallel word and all 15 serial bits.
  task automatic send_word(input logic [10:0] d, input logic [3:0] inj,
                           input logic [14:0] exp, input string nm);
    int t;
    @(negedge clk);
    bus.in_data  = d;
    bus.inj_pos  = inj;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_timeout: in_ready=%b want 1", nm, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cw !== exp) begin
      n_err++;
      $display("FAIL %s cw: got %h want %h", nm, bus.cw, exp);
    end
    n_cmp++;
    if (bus.cw_valid !== 1'b1 || bus.sof !== 1'b1 || bus.ser_valid !== 1'b1 || bus.eof !== 1'b0) begin
      n_err++;
      $display("FAIL %s first_bit_flags: cw_valid=%b sof=%b ser_valid=%b eof=%b want 1 1 1 0",
               nm, bus.cw_valid, bus.sof, bus.ser_valid, bus.eof);
    end
    n_cmp++;
    if (bus.ser_out !== exp[0]) begin
      n_err++;
      $display("FAIL %s ser_bit0: got %b want %b", nm, bus.ser_out, exp[0]);
    end
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.ser_out !== exp[k] || bus.ser_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s ser_bit%0d: got %b valid %b want %b valid 1",
                 nm, k, bus.ser_out, bus.ser_valid, exp[k]);
      end
      n_cmp++;
      if (bus.sof !== 1'b0 || bus.cw_valid !== 1'b0 || bus.eof !== (k == 14) || bus.cw !== exp) begin
        n_err++;
        $display("FAIL %s flags_bit%0d: sof=%b cw_valid=%b eof=%b cw=%h want 0 0 %b %h",
                 nm, k, bus.sof, bus.cw_valid, bus.eof, bus.cw, (k == 14), exp);
      end
    end
    exp_ws = exp_ws + 16'd1;
    @(negedge clk);
    n_cmp++;
    if (bus.ser_valid !== 1'b0 || bus.eof !== 1'b0 || bus.ser_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after: ser_valid=%b eof=%b ser_out=%b want 0 0 0",
               nm, bus.ser_valid, bus.eof, bus.ser_out);
    end
    n_cmp++;
    if (bus.words_sent !== exp_ws) begin
      n_err++;
      $display("FAIL %s words_sent: got %0d want %0d", nm, bus.words_sent, exp_ws);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 11'd0;
    bus.inj_pos  = 4'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset in_ready: got %b want 0", bus.in_ready);
    end
    n_cmp++;
    if (bus.cw !== 15'h0000 || bus.cw_valid !== 1'b0 || bus.ser_out !== 1'b0 ||
        bus.ser_valid !== 1'b0 || bus.sof !== 1'b0 || bus.eof !== 1'b0 || bus.words_sent !== 16'd0) begin
      n_err++;
      $display("FAIL reset outputs: cw=%h cv=%b so=%b sv=%b sof=%b eof=%b ws=%0d want all 0",
               bus.cw, bus.cw_valid, bus.ser_out, bus.ser_valid, bus.sof, bus.eof, bus.words_sent);
    end
    rst = 1'b0;
    exp_ws = 16'd0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_abort();
    int t;
    logic seen_eof;
    @(negedge clk);
    bus.in_data  = 11'h7FF;
    bus.inj_pos  = 4'd0;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    n_cmp++;
    if (bus.ser_out !== 1'b1 || bus.ser_valid !== 1'b1) begin
      n_err++;
      $display("FAIL abort bit7: ser_out=%b ser_valid=%b want 1 1", bus.ser_out, bus.ser_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.cw !== 15'h0000 || bus.cw_valid !== 1'b0 || bus.ser_out !== 1'b0 || bus.ser_valid !== 1'b0 ||
        bus.sof !== 1'b0 || bus.eof !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort outputs: cw=%h cv=%b so=%b sv=%b sof=%b eof=%b rdy=%b want all 0",
               bus.cw, bus.cw_valid, bus.ser_out, bus.ser_valid, bus.sof, bus.eof, bus.in_ready);
    end
    n_cmp++;
    if (bus.words_sent !== exp_ws) begin
      n_err++;
      $display("FAIL abort words_sent: got %0d want %0d", bus.words_sent, exp_ws);
    end
    rst = 1'b0;
    seen_eof = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.eof !== 1'b0 || bus.ser_valid !== 1'b0) seen_eof = 1'b1;
    end
    n_cmp++;
    if (seen_eof !== 1'b0) begin
      n_err++;
      $display("FAIL abort tail: leftover eof/ser_valid seen=%b want 0", seen_eof);
    end
    send_word(11'h001, 4'd0, 15'h0007, "abort_restart");
  endtask

  task automatic test_encode();
    send_word(11'h000, 4'd0, 15'h0000, "enc_000");
    send_word(11'h400, 4'd0, 15'h408B, "enc_400");
    send_word(11'h7FF, 4'd0, 15'h7FFF, "enc_7ff");
  endtask

  task automatic test_inject();
    logic [14:0] c;
    logic [3:0]  s;
    logic [10:0] q;
    send_word(11'h000, 4'd3, 15'h0004, "inj_3");
    c = bus.cw;
    s = 4'd0;
    for (int k = 0; k < 15; k++) begin
      if (c[k]) s = s ^ 4'(k + 1);
    end
    if (s != 4'd0) c[s - 4'd1] = ~c[s - 4'd1];
    q = {c[14], c[13], c[12], c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
    n_cmp++;
    if (s !== 4'd3 || q !== 11'h000) begin
      n_err++;
      $display("FAIL inj_decode: syndrome=%0d q=%h want 3 000", s, q);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bd [3];
    logic [14:0] bc [3];
    int f;
    int k;
    int nvalid;
    bd[0] = 11'h001; bc[0] = 15'h0007;
    bd[1] = 11'h400; bc[1] = 15'h408B;
    bd[2] = 11'h7FF; bc[2] = 15'h7FFF;
    nvalid = 0;
    @(negedge clk);
    bus.in_data  = bd[0];
    bus.inj_pos  = 4'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      f = i / 15;
      k = i % 15;
      if (bus.ser_valid === 1'b1) nvalid++;
      n_cmp++;
      if (bus.ser_out !== bc[f][k] || bus.sof !== (k == 0) || bus.eof !== (k == 14) ||
          bus.in_ready !== (k == 14)) begin
        n_err++;
        $display("FAIL b2b f%0d b%0d: so=%b sof=%b eof=%b rdy=%b want %b %b %b %b",
                 f, k, bus.ser_out, bus.sof, bus.eof, bus.in_ready,
                 bc[f][k], (k == 0), (k == 14), (k == 14));
      end
      if (k == 0) begin
        n_cmp++;
        if (bus.cw !== bc[f] || bus.cw_valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b cw f%0d: got %h valid %b want %h valid 1", f, bus.cw, bus.cw_valid, bc[f]);
        end
        if (f < 2) bus.in_data = bd[f + 1];
        else bus.in_valid = 1'b0;
      end
    end
    exp_ws = exp_ws + 16'd3;
    n_cmp++;
    if (nvalid !== 45) begin
      n_err++;
      $display("FAIL b2b ser_valid_cycles: got %0d want 45", nvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ser_valid !== 1'b0 || bus.words_sent !== exp_ws) begin
      n_err++;
      $display("FAIL b2b end: ser_valid=%b words_sent=%0d want 0 %0d", bus.ser_valid, bus.words_sent, exp_ws);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.words_sent_r = 16'hFFFF;
    #1;
    release dut.words_sent_r;
    exp_ws = 16'hFFFF;
    send_word(11'h000, 4'd0, 15'h0000, "wrap");
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    exp_ws = 16'd0;
    rst    = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 11'd0;
    bus.inj_pos  = 4'd0;
    test_reset();
    test_abort();
    test_encode();
    test_inject();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
